// File: rtl/sram_axi_bridge.sv
// -----------------------------------------------------------------------------
// sram_axi_bridge
//
// Purpose:
//   Converts the core's two SRAM-like ports (instruction and data; each with
//   req / addr_ok / data_ok handshakes) into a single AXI3 master.
//   - AR channel: one arbiter, data reads win over instruction reads.
//     At most one read per ID may be outstanding.
//   - W channel: single-beat write engine, at most one write in flight.
//   - R channel: the beat is routed to the port that owns its RID.
//     The RID is also exported to the core on axi_arid.
//   - Read-after-write protection.
//     By default, every read is held off while a write is in flight.
//     With BRIDGE_RAW_ADDR_CHECK_EN defined, only a read to the same
//     word as the pending write is held off.
//
// Configuration macro:
//   BRIDGE_RAW_ADDR_CHECK_EN  address-qualified read-after-write blocking
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   inst_sram_*                         instruction SRAM-like port (read only)
//   data_sram_*                         data SRAM-like port (read / write)
//   axi_arid                            RID of the current R beat (to core)
//   ar*/r*/aw*/w*/b*                    AXI3 master channels
// -----------------------------------------------------------------------------
module sram_axi_bridge #(
  parameter logic [3:0] INST_ARID = 4'd0,
  parameter logic [3:0] DATA_ARID = 4'd1,
  parameter logic [3:0] WR_ID     = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  axi_arid,
  // AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ar_state_e   ar_state_q, ar_state_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [1:0]  ar_size_q, ar_size_d;
  logic        arvalid_q, arvalid_d;

  w_state_e    w_state_q, w_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [1:0]  aw_size_q, aw_size_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [31:0] w_data_q, w_data_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;

  logic        inst_busy_q, inst_busy_d;
  logic        data_busy_q, data_busy_d;
  logic        rready_q, rready_d;
  logic        bready_q, bready_d;

  // ---------------------------------------------------------------------------
  // Request decode and arbitration
  // ---------------------------------------------------------------------------
  logic inst_rd_req, data_rd_req, data_wr_req;
  logic w_pending, inst_raw, data_raw;
  logic data_rd_grant, inst_rd_grant, wr_accept;
  logic ar_data_sending, ar_hs;
  logic r_hit_inst, r_hit_data, b_hit;

  always_comb begin
    // An instruction "write" is not a legal request; it is simply ignored.
    inst_rd_req = inst_sram_req & ~inst_sram_wr;
    data_rd_req = data_sram_req & ~data_sram_wr;
    data_wr_req = data_sram_req &  data_sram_wr;

    w_pending = (w_state_q != W_IDLE);
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    inst_raw = w_pending & (inst_sram_addr[31:2] == aw_addr_q[31:2]);
    data_raw = w_pending & (data_sram_addr[31:2] == aw_addr_q[31:2]);
`else
    inst_raw = w_pending;
    data_raw = w_pending;
`endif

    data_rd_grant = (ar_state_q == AR_IDLE) & data_rd_req & ~data_busy_q & ~data_raw;
    inst_rd_grant = (ar_state_q == AR_IDLE) & inst_rd_req & ~inst_busy_q & ~inst_raw
                    & ~data_rd_grant;

    // A write must not overtake a data read that is still in the pipe, and
    // a read granted in the same cycle goes first.
    ar_data_sending = (ar_state_q == AR_SEND) & (ar_id_q == DATA_ARID);
    wr_accept = (w_state_q == W_IDLE) & data_wr_req & ~data_busy_q & ~ar_data_sending
                & ~inst_rd_grant;

    ar_hs = arvalid_q & arready;

    // Beats are only delivered for reads this bridge actually has in flight,
    // so stale responses after a reset cannot produce a data_ok.
    r_hit_inst = rvalid & rready_q & (rid == INST_ARID) & inst_busy_q;
    r_hit_data = rvalid & rready_q & (rid == DATA_ARID) & data_busy_q;
    b_hit      = bvalid & bready_q & (w_state_q == W_RESP);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ar_state_d  = ar_state_q;
    ar_id_d     = ar_id_q;
    ar_addr_d   = ar_addr_q;
    ar_size_d   = ar_size_q;
    arvalid_d   = arvalid_q;
    w_state_d   = w_state_q;
    aw_addr_d   = aw_addr_q;
    aw_size_d   = aw_size_q;
    w_strb_d    = w_strb_q;
    w_data_d    = w_data_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    inst_busy_d = inst_busy_q;
    data_busy_d = data_busy_q;
    rready_d    = 1'b1;
    bready_d    = 1'b1;

    // AR engine
    case (ar_state_q)
      AR_IDLE: begin
        if (data_rd_grant) begin
          ar_id_d    = DATA_ARID;
          ar_addr_d  = data_sram_addr;
          ar_size_d  = data_sram_size;
          arvalid_d  = 1'b1;
          ar_state_d = AR_SEND;
        end else if (inst_rd_grant) begin
          ar_id_d    = INST_ARID;
          ar_addr_d  = inst_sram_addr;
          ar_size_d  = inst_sram_size;
          arvalid_d  = 1'b1;
          ar_state_d = AR_SEND;
        end
      end
      AR_SEND: begin
        if (arready) begin
          arvalid_d  = 1'b0;
          ar_state_d = AR_IDLE;
        end
      end
      default: begin
        arvalid_d  = 1'b0;
        ar_state_d = AR_IDLE;
      end
    endcase

    // Outstanding-read tracking: clear on the returning beat, set on AR
    // handshake. The same ID cannot do both in one cycle.
    if (r_hit_inst) inst_busy_d = 1'b0;
    if (r_hit_data) data_busy_d = 1'b0;
    if (ar_hs && (ar_id_q == INST_ARID)) inst_busy_d = 1'b1;
    if (ar_hs && (ar_id_q == DATA_ARID)) data_busy_d = 1'b1;

    // Write engine
    case (w_state_q)
      W_IDLE: begin
        if (wr_accept) begin
          aw_addr_d = data_sram_addr;
          aw_size_d = data_sram_size;
          w_strb_d  = data_sram_wstrb;
          w_data_d  = data_sram_wdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = W_SEND;
        end
      end
      W_SEND: begin
        // AW and W complete independently; wait for both.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_hit) w_state_d = W_IDLE;
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state_q  <= AR_IDLE;
      ar_id_q     <= 4'd0;
      ar_addr_q   <= 32'd0;
      ar_size_q   <= 2'd0;
      arvalid_q   <= 1'b0;
      w_state_q   <= W_IDLE;
      aw_addr_q   <= 32'd0;
      aw_size_q   <= 2'd0;
      w_strb_q    <= 4'd0;
      w_data_q    <= 32'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      inst_busy_q <= 1'b0;
      data_busy_q <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      ar_state_q  <= ar_state_d;
      ar_id_q     <= ar_id_d;
      ar_addr_q   <= ar_addr_d;
      ar_size_q   <= ar_size_d;
      arvalid_q   <= arvalid_d;
      w_state_q   <= w_state_d;
      aw_addr_q   <= aw_addr_d;
      aw_size_q   <= aw_size_d;
      w_strb_q    <= w_strb_d;
      w_data_q    <= w_data_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      inst_busy_q <= inst_busy_d;
      data_busy_q <= data_busy_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inst_sram_addr_ok = inst_rd_grant;
  assign data_sram_addr_ok = data_rd_grant | wr_accept;
  assign inst_sram_data_ok = r_hit_inst;
  assign data_sram_data_ok = r_hit_data | b_hit;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;
  assign axi_arid          = rid;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = WR_ID;
  assign awaddr  = aw_addr_q;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, aw_size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;

  assign wid     = WR_ID;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Inputs with no function in this bridge (single-beat, responses ignored).
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_axi_bridge
//
// Directed bench for sram_axi_bridge. The bench plays the AXI slave by hand
// and checks the core-side and AXI-side responses of the bridge.
//
// Timing: inputs are driven 1 time unit after a rising edge. Outputs are
// checked 1 time unit later, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  axi_arid;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;
  int aw_hs = 0;
  int w_hs = 0;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .axi_arid(axi_arid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count AXI write-side handshakes to prove each happens exactly once.
  always @(posedge clk) begin
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready)   w_hs  <= w_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    #1;
    // ---------------- reset state
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    tick(); tick();
    resetn = 1'b1;
    tick(); #1;
    chk("rready_on", rready, 1);
    chk("bready_on", bready, 1);
    chk("arburst_const", arburst, 2'b01);
    chk("arlen_const", arlen, 0);
    chk("wlast_const", wlast, 1);
    $display("step reset done");

    // ---------------- illegal inst write is ignored
    inst_sram_req = 1; inst_sram_wr = 1; inst_sram_addr = 32'h1C00_0000; #1;
    chk("inst_wr_ignored", inst_sram_addr_ok, 0);
    inst_sram_req = 0; inst_sram_wr = 0;

    // ---------------- 1: simultaneous inst and data read
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1000; #1;
    chk("t1_data_addr_ok", data_sram_addr_ok, 1);
    chk("t1_inst_addr_ok", inst_sram_addr_ok, 0);
    tick();
    data_sram_req = 0; #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid_data", arid, 4'd1);
    chk("t1_araddr_data", araddr, 32'h0000_1000);
    chk("t1_arsize", arsize, 3'b010);
    chk("t1_inst_wait", inst_sram_addr_ok, 0);
    arready = 1;
    tick();
    arready = 0; #1;
    chk("t1_inst_addr_ok2", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 0; #1;
    chk("t1_arid_inst", arid, 4'd0);
    chk("t1_araddr_inst", araddr, 32'h1C00_0000);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h1111_1111; #1;
    chk("t1_inst_data_ok", inst_sram_data_ok, 1);
    chk("t1_no_data_ok", data_sram_data_ok, 0);
    chk("t1_inst_rdata", inst_sram_rdata, 32'h1111_1111);
    tick();
    rid = 4'd1; rdata = 32'h2222_2222; #1;
    chk("t1_data_data_ok", data_sram_data_ok, 1);
    chk("t1_no_inst_ok", inst_sram_data_ok, 0);
    tick();
    rvalid = 0;
    $display("step 1 arbitration done");

    // ---------------- 2: AR stall for 5 cycles
    data_sram_req = 1; data_sram_addr = 32'h0000_2000; #1;
    chk("t2_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_arvalid_hold", arvalid, 1);
      chk("t2_araddr_hold", araddr, 32'h0000_2000);
      tick();
    end
    arready = 1;
    tick();
    arready = 0; #1;
    chk("t2_arvalid_drop", arvalid, 0);
    rvalid = 1; rid = 4'd1; rdata = 32'hDEAD_BEEF; #1;
    chk("t2_data_ok", data_sram_data_ok, 1);
    chk("t2_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    chk("t2_axi_arid", axi_arid, 4'd1);
    tick();
    rvalid = 0; #1;
    chk("t2_data_ok_once", data_sram_data_ok, 0);
    $display("step 2 ar stall done");

    // ---------------- 3: write with split AW/W ready
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h100;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1234; #1;
    chk("t3_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0; data_sram_wr = 0; #1;
    chk("t3_awvalid", awvalid, 1);
    chk("t3_wvalid", wvalid, 1);
    chk("t3_awaddr", awaddr, 32'h100);
    chk("t3_wstrb", wstrb, 4'b0011);
    chk("t3_wdata", wdata, 32'h1234);
    chk("t3_awid", awid, 4'd1);
    awready = 1;
    tick();
    awready = 0; #1;
    chk("t3_aw_dropped", awvalid, 0);
    chk("t3_w_held", wvalid, 1);
    wready = 1;
    tick();
    wready = 0; #1;
    chk("t3_w_dropped", wvalid, 0);
    chk("t3_aw_still_low", awvalid, 0);
    tick(); #1;
    chk("t3_no_early_ok", data_sram_data_ok, 0);
    bvalid = 1; #1;
    chk("t3_b_data_ok", data_sram_data_ok, 1);
    tick();
    bvalid = 0; #1;
    chk("t3_b_ok_once", data_sram_data_ok, 0);
    chk("t3_aw_hs_count", aw_hs, 1);
    chk("t3_w_hs_count", w_hs, 1);
    $display("step 3 write done");

    // ---------------- 4: read-after-write blocking
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h100; #1;
    chk("t4_wr_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0; data_sram_wr = 0;
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    data_sram_req = 1; data_sram_addr = 32'h100; #1;
    chk("t4_raw_block", data_sram_addr_ok, 0);
    tick(); #1;
    chk("t4_raw_block2", data_sram_addr_ok, 0);
    data_sram_addr = 32'h200; #1;
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    chk("t4_other_addr", data_sram_addr_ok, 1);
`else
    chk("t4_other_addr", data_sram_addr_ok, 0);
`endif
    data_sram_addr = 32'h100; #1;
    chk("t4_raw_block3", data_sram_addr_ok, 0);
    bvalid = 1; #1;
    chk("t4_b_data_ok", data_sram_data_ok, 1);
    chk("t4_block_during_b", data_sram_addr_ok, 0);
    tick();
    bvalid = 0; #1;
    chk("t4_read_after_b", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0; #1;
    chk("t4_araddr", araddr, 32'h100);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'h0000_5678; #1;
    chk("t4_r_data_ok", data_sram_data_ok, 1);
    tick();
    rvalid = 0;
    $display("step 4 raw done");

    // ---------------- 5: second inst read waits for first R beat
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0004; #1;
    chk("t5_first_ok", inst_sram_addr_ok, 1);
    tick();
    inst_sram_addr = 32'h1C00_0008;
    arready = 1;
    tick();
    arready = 0; #1;
    chk("t5_busy_block", inst_sram_addr_ok, 0);
    tick(); #1;
    chk("t5_busy_block2", inst_sram_addr_ok, 0);
    rvalid = 1; rid = 4'd0; rdata = 32'hCAFE_0004; #1;
    chk("t5_r_inst_ok", inst_sram_data_ok, 1);
    chk("t5_block_during_r", inst_sram_addr_ok, 0);
    tick();
    rvalid = 0; #1;
    chk("t5_second_ok", inst_sram_addr_ok, 1);
    inst_sram_req = 0;
    $display("step 5 inst outstanding done");

    // ---------------- 6: reset during arvalid
    tick();
    data_sram_req = 1; data_sram_addr = 32'h3000; #1;
    chk("t6_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0; #1;
    chk("t6_arvalid", arvalid, 1);
    resetn = 0; #1;
    chk("t6_arvalid_async_drop", arvalid, 0);
    tick();
    resetn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_inst_ok", inst_sram_data_ok, 0);
      chk("t6_no_data_ok", data_sram_data_ok, 0);
    end
    data_sram_req = 1; data_sram_addr = 32'h4000; #1;
    chk("t6_new_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0; #1;
    chk("t6_new_araddr", araddr, 32'h4000);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'h0000_4444; #1;
    chk("t6_new_data_ok", data_sram_data_ok, 1);
    tick();
    rvalid = 0;
    $display("step 6 reset recovery done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound in case the DUT or bench ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
